param_code_detector: RTL

//  Parametrised successor to the door-lock code detector. It accepts a start

---
 rtl/param_code_detector.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/param_code_detector.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : param_code_detector                                          |
// | Description : Programmable keypad code detector with unlock hold, error    |
// |               pulse and, when CODE_LOCKOUT_EN is defined, a lockout after  |
// |               MAX_FAILS consecutive wrong codes.                           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module param_code_detector #(
  parameter int                            NUM_BTN      = 3,
  parameter int                            CODE_LEN     = 4,
  parameter logic [NUM_BTN*CODE_LEN-1:0]   DEFAULT_CODE = 12'h88C,
  parameter int                            UNLOCK_CYC   = 4,
  parameter int                            MAX_FAILS    = 3,
  parameter int                            LOCK_CYC     = 16,
  localparam int                           IDX_W        = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               S,
  input  logic [NUM_BTN-1:0] Btn,
  input  logic               BtnVld,
  input  logic               CodeWr,
  input  logic [IDX_W-1:0]   CodeIdx,
  input  logic [NUM_BTN-1:0] CodeData,
  output logic               U,
  output logic               Err,
  output logic               Locked
);

  typedef enum logic [1:0] {
    ST_WAIT    = 2'd0,
    ST_ENTRY   = 2'd1,
    ST_UNLOCK  = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_t;

  localparam int               UCNT_W      = (UNLOCK_CYC > 1) ? $clog2(UNLOCK_CYC) : 1;
  localparam logic [IDX_W-1:0] c_IDX_LAST  = IDX_W'(CODE_LEN - 1);
  localparam logic [UCNT_W-1:0] c_UCNT_LAST = UCNT_W'(UNLOCK_CYC - 1);

  state_t             r_state;
  state_t             w_next;
  logic [IDX_W-1:0]   r_idx;
  logic               r_mismatch;
  logic [NUM_BTN-1:0] r_code [CODE_LEN];
  logic [UCNT_W-1:0]  r_ucnt;
  logic               r_u;
  logic               r_err;

  logic w_press_bad;
  logic w_last;
  logic w_fail;
  logic w_pass;
  logic w_code_wr;
  logic w_lock_trip;

  // A non-one-hot press can never match, even if the stored slot is itself non-one-hot.
  assign w_press_bad = !$onehot(Btn) || (Btn != r_code[r_idx]);
  assign w_last      = (r_state == ST_ENTRY) && S && BtnVld && (r_idx == c_IDX_LAST);
  assign w_fail      = w_last && (r_mismatch || w_press_bad);
  assign w_pass      = w_last && !(r_mismatch || w_press_bad);
  assign w_code_wr   = (r_state == ST_WAIT) && CodeWr && (32'(CodeIdx) < CODE_LEN);

`ifdef CODE_LOCKOUT_EN
  localparam int                FAIL_W      = $clog2(MAX_FAILS + 1);
  localparam int                LCNT_W      = (LOCK_CYC > 1) ? $clog2(LOCK_CYC) : 1;
  localparam logic [FAIL_W-1:0] c_FAIL_MAX  = FAIL_W'(MAX_FAILS);
  localparam logic [LCNT_W-1:0] c_LCNT_LAST = LCNT_W'(LOCK_CYC - 1);

  logic [FAIL_W-1:0] r_fails;
  logic [LCNT_W-1:0] r_lcnt;
  logic              r_locked;

  assign w_lock_trip = w_fail && (r_fails >= (c_FAIL_MAX - FAIL_W'(1)));
  assign Locked      = r_locked;

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_fails  <= '0;
      r_lcnt   <= '0;
      r_locked <= 1'b0;
    end else begin
      r_locked <= (w_next == ST_LOCKOUT);
      r_lcnt   <= (r_state == ST_LOCKOUT) ? r_lcnt + 1'b1 : '0;
      if (w_pass || ((r_state == ST_LOCKOUT) && (w_next == ST_WAIT)))
        r_fails <= '0;
      else if (w_fail && (r_fails != c_FAIL_MAX))
        r_fails <= r_fails + 1'b1;
    end
  end
`else
  // Failure-count parameters only shape the lockout build.
  if ((MAX_FAILS < 1) || (LOCK_CYC < 1)) begin : g_lockout_params_idle
  end

  assign w_lock_trip = 1'b0;
  assign Locked      = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_WAIT: begin
        if (S) w_next = ST_ENTRY;
      end
      ST_ENTRY: begin
        if (!S)          w_next = ST_WAIT;
        else if (w_pass) w_next = ST_UNLOCK;
        else if (w_fail) w_next = w_lock_trip ? ST_LOCKOUT : ST_WAIT;
      end
      ST_UNLOCK: begin
        if (r_ucnt == c_UCNT_LAST) w_next = ST_WAIT;
      end
      ST_LOCKOUT: begin
`ifdef CODE_LOCKOUT_EN
        if (r_lcnt == c_LCNT_LAST) w_next = ST_WAIT;
`else
        w_next = ST_WAIT;
`endif
      end
      default: w_next = ST_WAIT;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_state    <= ST_WAIT;
      r_idx      <= '0;
      r_mismatch <= 1'b0;
      r_ucnt     <= '0;
      r_u        <= 1'b0;
      r_err      <= 1'b0;
      for (int i = 0; i < CODE_LEN; i++)
        r_code[i] <= DEFAULT_CODE[i*NUM_BTN +: NUM_BTN];
    end else begin
      r_state <= w_next;
      r_u     <= (w_next == ST_UNLOCK);
      r_err   <= w_fail;
      r_ucnt  <= (r_state == ST_UNLOCK) ? r_ucnt + 1'b1 : '0;
      if (w_code_wr)
        r_code[CodeIdx] <= CodeData;
      // Every press is consumed so the error position is never revealed by timing.
      if (r_state == ST_WAIT) begin
        r_idx      <= '0;
        r_mismatch <= 1'b0;
      end else if ((r_state == ST_ENTRY) && BtnVld) begin
        r_idx      <= r_idx + 1'b1;
        r_mismatch <= r_mismatch | w_press_bad;
      end
    end
  end

  assign U   = r_u;
  assign Err = r_err;

endmodule
`default_nettype wire
